// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared VDP timing defaults, window geometry and coordinate helpers
package vdp_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_IRQ_ROW   = 432;

  // 256x192 VDP picture shown pixel-doubled inside the 640x480 raster
  localparam int WIN_X0    = 64;
  localparam int WIN_Y0    = 48;
  localparam int WIN_SCALE = 2;
  localparam int WIN_W     = 256;
  localparam int WIN_H     = 192;

  function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vdp_timing_if.sv
// rtl/vdp_timing_if.sv - raster position, sync and window outputs of vdp_timing
interface vdp_timing_if;
  import vdp_pkg::*;

  coord_t     col;
  coord_t     row;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       irq_tick;
  logic       frame_tick;
  logic       vdp_active;
  logic [7:0] vdp_col;
  logic [7:0] vdp_row;

  modport master (
    output col, row, hsync, vsync, active, irq_tick, frame_tick,
           vdp_active, vdp_col, vdp_row
  );

  modport slave (
    input col, row, hsync, vsync, active, irq_tick, frame_tick,
          vdp_active, vdp_col, vdp_row
  );

endinterface

// File: rtl/vdp_timing_counter.sv
// rtl/vdp_timing_counter.sv - modulo-N counter with count enable and registered terminal-count pulse
module vdp_timing_counter
  import vdp_pkg::*;
#(
  parameter int N = 800
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  output coord_t cnt,
  output logic   wrap
);

  coord_t cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (en) begin
      cnt_next = (cnt == coord_t'(N - 1)) ? '0 : cnt + coord_t'(1);
    end
  end

  // wrap is high while cnt sits at N-1, so an enabled wrap coincides with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      wrap <= (cnt_next == coord_t'(N - 1));
    end
  end

endmodule

// File: rtl/vdp_timing.sv
// rtl/vdp_timing.sv - 640x480 raster timing generator with irq/frame ticks
// VDP_TIMING_WINDOW_EN adds the pixel-doubled 256x192 VDP window decode
module vdp_timing
  import vdp_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int IRQ_ROW   = DEF_IRQ_ROW
) (
  input logic          clk,
  input logic          reset,
  vdp_timing_if.master vid
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam bit     IRQ_ON   = (IRQ_ROW < V_TOTAL);
  localparam coord_t IRQ_LINE = IRQ_ON ? coord_t'(IRQ_ROW) : '0;

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_wrap;
  logic   v_wrap;
  logic   at_origin;

  // Counters run one pixel ahead of the output registers
  vdp_timing_counter #(.N(H_TOTAL)) u_hcnt (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  vdp_timing_counter #(.N(V_TOTAL)) u_vcnt (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      at_origin <= 1'b1;
    end else begin
      at_origin <= h_wrap & v_wrap;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid.col        <= '0;
      vid.row        <= '0;
      vid.hsync      <= 1'b1;
      vid.vsync      <= 1'b1;
      vid.active     <= 1'b0;
      vid.irq_tick   <= 1'b0;
      vid.frame_tick <= 1'b0;
    end else begin
      vid.col        <= h_cnt;
      vid.row        <= v_cnt;
      vid.hsync      <= !in_span(h_cnt, HS_FIRST, HS_LAST);
      vid.vsync      <= !in_span(v_cnt, VS_FIRST, VS_LAST);
      vid.active     <= (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
      vid.irq_tick   <= IRQ_ON && (h_cnt == '0) && (v_cnt == IRQ_LINE);
      vid.frame_tick <= at_origin;
    end
  end

`ifdef VDP_TIMING_WINDOW_EN
  localparam coord_t WX0 = coord_t'(WIN_X0);
  localparam coord_t WX1 = coord_t'(WIN_X0 + WIN_W * WIN_SCALE - 1);
  localparam coord_t WY0 = coord_t'(WIN_Y0);
  localparam coord_t WY1 = coord_t'(WIN_Y0 + WIN_H * WIN_SCALE - 1);

  logic   in_win;
  coord_t dx;
  coord_t dy;

  always_comb begin
    in_win = in_span(h_cnt, WX0, WX1) && in_span(v_cnt, WY0, WY1);
    dx     = h_cnt - WX0;
    dy     = v_cnt - WY0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid.vdp_active <= 1'b0;
      vid.vdp_col    <= '0;
      vid.vdp_row    <= '0;
    end else begin
      vid.vdp_active <= in_win;
      vid.vdp_col    <= in_win ? 8'(dx / coord_t'(WIN_SCALE)) : 8'd0;
      vid.vdp_row    <= in_win ? 8'(dy / coord_t'(WIN_SCALE)) : 8'd0;
    end
  end
`else
  assign vid.vdp_active = 1'b0;
  assign vid.vdp_col    = 8'd0;
  assign vid.vdp_row    = 8'd0;
`endif

endmodule

// File: tb/tb_vdp_timing.sv
// tb/tb_vdp_timing.sv - bench for vdp_timing with a short frame; VDP_TIMING_WINDOW_EN selects window expectations
module tb_vdp_timing;

  localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_VIS = 12, V_FP = 2, V_SYNC = 2, V_BP = 3, IRQ = 9;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd_tick = 1'b0;
  logic irq_q;
  int   checks = 0;
  int   errors = 0;
  bit   run = 1'b0;
  int   pix = 0;

  vdp_timing_if vif ();
  vdp_timing_if vif_noirq ();

  always #5 clk = ~clk;

  vdp_timing #(
    .V_VISIBLE(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .IRQ_ROW(IRQ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vif)
  );

  vdp_timing #(
    .V_VISIBLE(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .IRQ_ROW(V_TOT)
  ) dut_noirq (
    .clk   (clk),
    .reset (reset),
    .vid   (vif_noirq)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // pix = pixels shown since the first edge after reset release
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      run <= 1'b0;
      pix <= 0;
    end else begin
      pix <= run ? pix + 1 : 0;
      run <= 1'b1;
    end
  end

  // stand-in for the downstream vdp_irq latch
  always @(posedge clk or negedge reset) begin
    if (!reset)            irq_q <= 1'b0;
    else if (vif.irq_tick) irq_q <= 1'b1;
    else if (rd_tick)      irq_q <= 1'b0;
  end

  function automatic logic [42:0] expect_vec(input bit r, input int p);
    int c, rw;
    logic hs, vs, act, irq, frm, va;
    logic [7:0] vc, vr;
    if (!r) return {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0};
    c   = p % H_TOT;
    rw  = (p / H_TOT) % V_TOT;
    hs  = !(c >= H_VIS + H_FP && c < H_VIS + H_FP + H_SYNC);
    vs  = !(rw >= V_VIS + V_FP && rw < V_VIS + V_FP + V_SYNC);
    act = (c < H_VIS) && (rw < V_VIS);
    irq = (c == 0) && (rw == IRQ);
    frm = (c == 0) && (rw == 0);
    va  = 1'b0;
    vc  = 8'd0;
    vr  = 8'd0;
`ifdef VDP_TIMING_WINDOW_EN
    if (c >= 64 && c < 64 + 512 && rw >= 48 && rw < 48 + 384) begin
      va = 1'b1;
      vc = 8'((c - 64) / 2);
      vr = 8'((rw - 48) / 2);
    end
`endif
    return {10'(c), 10'(rw), hs, vs, act, irq, frm, va, vc, vr, 1'b0};
  endfunction

  always @(negedge clk) begin
    chk("outputs",
        {vif.col, vif.row, vif.hsync, vif.vsync, vif.active, vif.irq_tick, vif.frame_tick,
         vif.vdp_active, vif.vdp_col, vif.vdp_row, vif_noirq.irq_tick},
        expect_vec(run, pix));
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at pix %0d", pix);
    $fatal(1);
  end

  initial begin
    int hs_lo, hs_hi, vs_lo, vs_hi, nframe, nirq, irq_row, irq_col, first_irq;
    hs_lo = 9999; hs_hi = -1; vs_lo = 9999; vs_hi = -1;
    nframe = 0; nirq = 0; irq_row = -1; irq_col = -1; first_irq = -1;

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        {vif.col, vif.row, vif.hsync, vif.vsync, vif.active, vif.irq_tick, vif.frame_tick,
         vif.vdp_active, vif.vdp_col, vif.vdp_row},
        {20'd0, 2'b11, 4'b0000, 16'd0});
    @(negedge clk) reset = 1'b1;

    for (int n = 0; n < FRAME; n++) begin
      @(posedge clk);
      #1;
      rd_tick = (n == 11 * H_TOT);
      if (n == 0)
        chk("release_pixel",
            {vif.col, vif.row, vif.active, vif.frame_tick, vif.hsync, vif.vsync},
            {10'd0, 10'd0, 4'b1111});
      if (n < H_TOT && !vif.hsync) begin
        if (int'(vif.col) < hs_lo) hs_lo = int'(vif.col);
        if (int'(vif.col) > hs_hi) hs_hi = int'(vif.col);
      end
      if (n == H_TOT - 1) chk("line_end", {vif.col, vif.row}, {10'd799, 10'd0});
      if (n == H_TOT)     chk("line_wrap", {vif.col, vif.row}, {10'd0, 10'd1});
      if (!vif.vsync) begin
        if (int'(vif.row) < vs_lo) vs_lo = int'(vif.row);
        if (int'(vif.row) > vs_hi) vs_hi = int'(vif.row);
      end
      if (vif.frame_tick) nframe++;
      if (vif.irq_tick) begin
        nirq++;
        irq_row = int'(vif.row);
        irq_col = int'(vif.col);
      end
      if (n == 7200)  chk("irq_latch_idle", irq_q, 1'b0);
      if (n == 7201)  chk("irq_latch_set", irq_q, 1'b1);
      if (n == 8801)  chk("irq_latch_clear", irq_q, 1'b0);
    end
    rd_tick = 1'b0;

    chk("hsync_first_col", hs_lo, 656);
    chk("hsync_last_col", hs_hi, 751);
    chk("vsync_first_row", vs_lo, 14);
    chk("vsync_last_row", vs_hi, 15);
    chk("frame_tick_count", nframe, 1);
    chk("irq_tick_count", nirq, 1);
    chk("irq_tick_pos", {irq_row[9:0], irq_col[9:0]}, {10'd9, 10'd0});

    for (int k = 0; k < FRAME && !(vif.row == 10'd5 && vif.col == 10'd123); k++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_mid_frame", {vif.row, vif.col}, {10'd5, 10'd123});
    #1 reset = 1'b0;
    #1;
    chk("mid_reset_state",
        {vif.col, vif.row, vif.hsync, vif.vsync, vif.active, vif.irq_tick, vif.frame_tick,
         vif.vdp_active, vif.vdp_col, vif.vdp_row},
        {20'd0, 2'b11, 4'b0000, 16'd0});
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    for (int n = 0; n < 20000; n++) begin
      @(posedge clk);
      #1;
      if (vif.irq_tick) begin
        first_irq = n;
        break;
      end
    end
    chk("irq_after_reset", first_irq, 7200);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vdp_timing.md
VDP_TIMING -- requirements
Module: vdp_timing

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- IRQ_ROW, 432, line whose column 0 raises irq_tick
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock; sole clock
- reset, in, 1, asynchronous, active-low reset
- col, out, 10, current pixel column, 0..H_total-1
- row, out, 10, current line, 0..V_total-1
- hsync, out, 1, horizontal sync, active-low
- vsync, out, 1, vertical sync, active-low
- active, out, 1, current pixel is inside the 640x480 visible area
- irq_tick, out, 1, one-clk pulse to the vdp_irq block's irq_tick input
- frame_tick, out, 1, one-clk pulse at col=0,row=0
- vdp_active, out, 1, pixel is inside the 256x192 doubled VDP window
- vdp_col, out, 8, VDP pixel x (0..255)
- vdp_row, out, 8, VDP pixel y (0..191)

Function
REQ-003 H_total = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_total = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
REQ-004 col increments by 1 every clk and wraps from H_total-1 to 0.
REQ-005 row increments when col wraps, and wraps from V_total-1 to 0 in the same clk that col wraps.
REQ-006 All outputs are registered and mutually aligned; every output describes the pixel at (col,row) in the same cycle.
REQ-007 hsync = 0 exactly for col in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] (656..751).
REQ-008 vsync = 0 exactly for row in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] (490..491), for every col of those rows.
REQ-009 active = 1 exactly when col<H_VISIBLE and row<V_VISIBLE.
REQ-010 irq_tick = 1 for exactly one clk per frame, at col=0,row=IRQ_ROW; it is 0 at all other times.
REQ-011 frame_tick = 1 for exactly one clk per frame, at col=0,row=0.
REQ-012 A parameter set with IRQ_ROW>=V_total yields no irq_tick; this is legal and not an error.
REQ-013 Counter widths are 10 bits; parameters whose totals exceed 1024 are unsupported.

Reset
REQ-014 While reset=0: col=0, row=0, hsync=1, vsync=1, active=0, irq_tick=0, frame_tick=0, vdp_active=0, vdp_col=0, vdp_row=0.
REQ-015 On the first clk edge after reset rises, outputs present pixel (0,0): active=1 and frame_tick=1.
REQ-016 Reset asserted mid-frame returns all outputs to the REQ-014 values immediately, without waiting for a clk edge; no irq_tick is emitted by the abort.

Configuration
REQ-017 With VDP_TIMING_WINDOW_EN defined, the VDP window is 512x384 screen pixels with its origin at (64,48).
- vdp_active=1 inside that window.
- vdp_col=(col-64)>>1 and vdp_row=(row-48)>>1 inside the window; both are 0 outside it.
REQ-018 Without VDP_TIMING_WINDOW_EN, vdp_active, vdp_col and vdp_row are tied to 0, and no window logic is synthesized.

Structure
REQ-019 Default timing constants (the REQ-001 defaults plus window origin 64/48 and scale 2) live in shared package vdp_pkg, which vdp_irq and other VDP blocks also use.
REQ-020 One sub-module, vdp_timing_counter: a parameterized modulo-N counter with a count-enable input and a registered wrap pulse.
- It is instantiated twice: horizontal, and vertical enabled by the horizontal wrap.

Verification
REQ-021 The bench covers at least these directed scenarios:
- Reset release: reset low for 3 clks, then high -> the first edge shows col=0, row=0, active=1, frame_tick=1, hsync=1, vsync=1.
- Line timing: run 800 clks -> hsync low exactly for col 656..751; col wraps 799->0 and row steps 0->1 in the same clk.
- Frame timing: run 420000 clks -> exactly one frame_tick and exactly one irq_tick (at row 432, col 0); vsync low exactly for rows 490..491.
- irq path: connect vdp_irq and hold rd_tick=0 -> irq goes high the clk after irq_tick at row 432; a rd_tick at row 440 clears it.
- Mid-frame reset: assert reset at row 300, col 123 -> outputs take REQ-014 values immediately; no irq_tick occurs until 432 lines after release.
- Window (macro on): at col=64,row=48 -> vdp_active=1, vdp_col=0, vdp_row=0; at col=575,row=431 -> vdp_col=255, vdp_row=191; at col=576 -> vdp_active=0. With the macro off, all three stay 0 for a full frame.
